// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared constants and helpers for sync_fifo_param         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int fifo_clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_ram : DATA_W x DEPTH register array, sync write, async read    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO with thresholds,   |
// | sticky error flags, flush and optional FWFT read.  Rev 1.0          |
// +--------------------------------------------------------------------+
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = MODE_STD,
    localparam int ADDR_W  = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_full,
    output logic              buf_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_counter,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_full_cnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_af_cnt   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_ae_cnt   = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rd_data;

    // Every flag is a pure decode of the registered count.
    assign buf_full     = (r_count == c_full_cnt);
    assign buf_empty    = (r_count == '0);
    assign almost_full  = (r_count >= c_af_cnt);
    assign almost_empty = (r_count <= c_ae_cnt);
    assign fifo_counter = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en & ~buf_full;
    assign w_rd_acc = rd_en & ~buf_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && buf_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && buf_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Flush must also suppress the RAM write that would otherwise land that cycle.
    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_acc & ~flush),
        .wr_addr (r_wr_ptr),
        .wr_data (buf_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            assign buf_out = buf_empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [DATA_W-1:0] r_dout;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                end else if (flush) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= w_rd_data;
                end
            end

            assign buf_out = r_dout;
        end
    endgenerate

endmodule : sync_fifo_param
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised successor to the team's fixed 8x64 synchronous FIFO.
- Configurable data width and depth.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.
- Single clock domain; used as the standard buffering element between producer/consumer blocks in the datapath.

Parameters:
- DATA_W, 8: data word width in bits (>=1).
- DEPTH, 64: number of entries; power of 2, >=4.
- AF_LEVEL, DEPTH-4: almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear, highest priority
- wr_en  in  1  write request
- buf_in  in  DATA_W  write data
- rd_en  in  1  read request (pop/acknowledge in FWFT mode)
- buf_out  out  DATA_W  read data
- buf_full  out  1  count == DEPTH
- buf_empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- fifo_counter  out  ADDR_W+1  occupancy 0..DEPTH; ADDR_W = clog2(DEPTH)
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset: one clock; asynchronous active-low (rst_n low clears immediately, independent of clk). Reset values:
  - wr_ptr = 0, rd_ptr = 0, fifo_counter = 0, buf_out = 0.
  - buf_empty = 1, buf_full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation: all state above returns to reset values at once; any in-flight write or read is lost.
- Accept rules: write accepted iff wr_en && !buf_full; read accepted iff rd_en && !buf_empty. Evaluated on the registered flags at the clock edge.
- Accepted write: mem[wr_ptr] <= buf_in; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Counter update:
  - +1 on write-only, -1 on read-only.
  - Unchanged when both are accepted in the same cycle, or when neither is.
- Simultaneous wr_en and rd_en:
  - When full: only the read is accepted; the write is rejected and sets overflow.
  - When empty: only the write is accepted; the read is rejected and sets underflow.
- All status flags decode combinationally from the fifo_counter register. They therefore change in the cycle after the accepted operation's edge.
- Rejected requests:
  - wr_en && buf_full sets overflow; rd_en && buf_empty sets underflow.
  - No pointer, counter, memory or buf_out change.
  - overflow and underflow hold until flush or reset.
- flush (rst_n high):
  - On the next edge, pointers, counter, overflow, underflow and buf_out go to 0.
  - wr_en and rd_en in that cycle are ignored.
  - Memory is untouched.
- FWFT=0:
  - On an accepted read, buf_out <= mem[rd_ptr]; data is valid the cycle after the read edge (latency 1).
  - buf_out holds its value otherwise.
- FWFT=1:
  - buf_out = mem[rd_ptr] whenever buf_empty = 0; buf_out = 0 when empty.
  - rd_en pops the displayed word; the next word appears the cycle after the pop edge.
  - Write to empty FIFO -> word visible on buf_out the cycle after the write edge, when buf_empty deasserts.
- Width rule: fifo_counter is ADDR_W+1 bits so that it can represent DEPTH without aliasing.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 function / ADDR_W derivation;
  - default DATA_W, DEPTH and threshold constants;
  - the FWFT mode encodings (MODE_STD = 0, MODE_FWFT = 1).
- One sub-module, fifo_ram: simple dual-port register array, DATA_W x DEPTH, synchronous write, asynchronous read address.
- Control logic (pointers, counter, flags, output register/mux) stays in sync_fifo_param.

Test Plan:
- Bench configuration for all scenarios: DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
- Reset/fill: reset, then write 0x10..0x17 on 8 consecutive edges.
  -> fifo_counter = 8, buf_full = 1, almost_full = 1 after the 6th write, buf_empty = 0.
  -> A 9th write (0xFF) sets overflow = 1 and leaves fifo_counter = 8.
- Drain/order (FWFT=0): from full, 8 reads.
  -> buf_out = 0x10..0x17 in order, each one cycle after its read edge; buf_empty = 1 at the end.
  -> A further read sets underflow = 1 and buf_out holds 0x17.
- Wrap and simultaneous ops: fill 5 words, then 20 cycles of wr_en = rd_en = 1 with incrementing data.
  -> fifo_counter stays 5; output sequence continuous across pointer wrap; no flag errors.
- Boundary simultaneity:
  -> At full, with wr_en = rd_en = 1: read accepted, write rejected, counter becomes 7, overflow = 1.
  -> At empty, with both asserted: write accepted, counter becomes 1, underflow = 1.
- FWFT=1: write 0xA5 to empty FIFO.
  -> buf_out = 0xA5 the next cycle with rd_en = 0.
  -> Pulse rd_en: buf_empty = 1 and buf_out = 0 the following cycle.
- Flush and reset mid-stream: with 4 words stored and overflow = 1, pulse flush alongside wr_en.
  -> Next cycle fifo_counter = 0, overflow = 0, write ignored.
  -> rst_n low between clock edges clears all outputs immediately.
